// File: rtl/qam_pkg.sv
// Shared constants and types for the 4-QAM mixer/demodulator pair.
package qam_pkg;

  localparam int unsigned DEF_SAMPLE_W = 8;
  localparam int unsigned SYM_W        = 2;

  // Symbol bit positions, identical on the transmit side.
  localparam int unsigned SIN_BIT = 1;
  localparam int unsigned COS_BIT = 0;

  typedef enum logic {
    IDLE,
    INTEG
  } demod_state_e;

endpackage

// File: rtl/qam_correlator.sv
// One multiply-accumulate arm: accumulates a*b over a symbol period.
module qam_correlator
  import qam_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       load,
  input  logic                       clr,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [ACC_W-1:0]    acc
);

  localparam int unsigned PROD_W = 2 * SAMPLE_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod     = PROD_W'(a) * PROD_W'(b);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // Running correlation including the current sample; this is the final
  // metric when the current sample closes the symbol.
  assign acc = acc_q + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en) begin
      if (clr) begin
        acc_q <= '0;
      end else if (load) begin
        acc_q <= prod_ext;
      end else begin
        acc_q <= acc;
      end
    end
  end

endmodule

// File: rtl/qam_demod.sv
// Coherent 4-QAM demodulator: correlates against sin/cos references over a
// symbol and slices the sign of each arm.
module qam_demod
  import qam_pkg::*;
#(
  parameter int unsigned SPS      = 16,
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic                       sym_start,
  input  logic signed [SAMPLE_W-1:0] signal_in,
  input  logic signed [SAMPLE_W-1:0] sin_ref,
  input  logic signed [SAMPLE_W-1:0] cos_ref,
  output logic [SYM_W-1:0]           data_out,
  output logic                       data_valid,
  output logic signed [ACC_W-1:0]    i_metric,
  output logic signed [ACC_W-1:0]    q_metric,
  output logic                       sync_err
);

  localparam int unsigned CNT_W = $clog2(SPS);

  if (SPS < 2) begin : g_sps_check
    $error("qam_demod: SPS must be at least 2");
  end

  if (ACC_W < 2 * SAMPLE_W + $clog2(SPS)) begin : g_acc_w_check
    $error("qam_demod: ACC_W too narrow for SPS products of SAMPLE_W");
  end

  demod_state_e           state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   start;
  logic                   last;
  logic                   acc_en;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;

  assign start  = sample_valid & sym_start;
  // A sym_start on the final sample restarts rather than completes.
  assign last   = sample_valid & ~sym_start & (state_q == INTEG) &
                  (cnt_q == CNT_W'(SPS - 1));
  assign acc_en = sample_valid & ((state_q == INTEG) | sym_start);

  qam_correlator #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_sin_arm (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_en),
    .load (start),
    .clr  (last),
    .a    (signal_in),
    .b    (sin_ref),
    .acc  (sum_i)
  );

  qam_correlator #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_cos_arm (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_en),
    .load (start),
    .clr  (last),
    .a    (signal_in),
    .b    (cos_ref),
    .acc  (sum_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      i_metric   <= '0;
      q_metric   <= '0;
      sync_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (sample_valid) begin
        unique case (state_q)
          IDLE: begin
            if (sym_start) begin
              state_q <= INTEG;
              cnt_q   <= CNT_W'(1);
            end
          end
          INTEG: begin
            if (sym_start) begin
              cnt_q <= CNT_W'(1);
              if (cnt_q != '0) begin
                sync_err <= 1'b1;
              end
            end else if (last) begin
              cnt_q             <= '0;
              i_metric          <= sum_i;
              q_metric          <= sum_q;
              data_out[SIN_BIT] <= ~sum_i[ACC_W-1];
              data_out[COS_BIT] <= ~sum_q[ACC_W-1];
              data_valid        <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qam_demod.sv
// Bench for qam_demod: directed vector table, reset/resync sequences,
// randomized traffic against a symbol-level model, and a wide-SPS overflow case.
module tb_qam_demod;

  localparam int SPS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              sample_valid = 1'b0;
  logic              sym_start    = 1'b0;
  logic signed [7:0] signal_in    = '0;
  logic signed [7:0] sin_ref      = '0;
  logic signed [7:0] cos_ref      = '0;
  logic [1:0]         data_out;
  logic               data_valid;
  logic signed [19:0] i_metric;
  logic signed [19:0] q_metric;
  logic               sync_err;

  logic              sv16  = 1'b0;
  logic              ss16  = 1'b0;
  logic signed [7:0] sig16 = '0;
  logic signed [7:0] sin16 = '0;
  logic signed [7:0] cos16 = '0;
  logic [1:0]         do16;
  logic               dv16;
  logic signed [19:0] i16;
  logic signed [19:0] q16;
  logic               se16;

  always #5 clk = ~clk;

  qam_demod #(.SPS(SPS), .SAMPLE_W(8), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sym_start(sym_start),
    .signal_in(signal_in), .sin_ref(sin_ref), .cos_ref(cos_ref),
    .data_out(data_out), .data_valid(data_valid), .i_metric(i_metric),
    .q_metric(q_metric), .sync_err(sync_err)
  );

  qam_demod #(.SPS(16), .SAMPLE_W(8), .ACC_W(20)) dut16 (
    .clk(clk), .rst(rst), .sample_valid(sv16), .sym_start(ss16),
    .signal_in(sig16), .sin_ref(sin16), .cos_ref(cos16),
    .data_out(do16), .data_valid(dv16), .i_metric(i16),
    .q_metric(q16), .sync_err(se16)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Symbol-level model: collect the samples of the current symbol, and when
  // SPS have arrived compute both correlations with plain integer arithmetic.
  int  q_sig[$];
  int  q_sin[$];
  int  q_cos[$];
  bit  m_active;
  bit  m_dv;
  bit  m_se;
  bit [1:0] m_do;
  int  m_i;
  int  m_q;

  task automatic model_reset();
    q_sig.delete(); q_sin.delete(); q_cos.delete();
    m_active = 0; m_dv = 0; m_se = 0; m_do = 2'b00; m_i = 0; m_q = 0;
  endtask

  task automatic model_edge(input bit v, input bit s, input int sg, input int sn,
                            input int cs);
    int si;
    int sq;
    m_dv = 0;
    m_se = 0;
    if (!rst) begin
      model_reset();
    end else if (v) begin
      if (s) begin
        if (m_active && q_sig.size() != 0) m_se = 1;
        q_sig.delete(); q_sin.delete(); q_cos.delete();
        m_active = 1;
      end
      if (m_active) begin
        q_sig.push_back(sg); q_sin.push_back(sn); q_cos.push_back(cs);
        if (q_sig.size() == SPS) begin
          si = 0;
          sq = 0;
          for (int k = 0; k < SPS; k++) begin
            si += q_sig[k] * q_sin[k];
            sq += q_sig[k] * q_cos[k];
          end
          m_i  = si;
          m_q  = sq;
          m_do = {si >= 0, sq >= 0};
          m_dv = 1;
          q_sig.delete(); q_sin.delete(); q_cos.delete();
        end
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input int sg, input int sn, input int cs);
    sample_valid = v;
    sym_start    = s;
    signal_in    = sg[7:0];
    sin_ref      = sn[7:0];
    cos_ref      = cs[7:0];
    @(posedge clk);
    model_edge(v, s, sg, sn, cs);
    #1;
    chk("model data_valid", data_valid, m_dv);
    chk("model sync_err", sync_err, m_se);
    chk("model data_out", data_out, m_do);
    chk("model i_metric", i_metric, m_i);
    chk("model q_metric", q_metric, m_q);
  endtask

  typedef struct {
    bit       sv;
    bit       ss;
    int       sig;
    int       ph;
    bit       dv;
    bit [1:0] dout;
    int       im;
    int       qm;
    bit       se;
  } vec_t;

  vec_t tab[$];
  int   sin_t[4] = '{0, 60, 0, -60};
  int   cos_t[4] = '{60, 0, -60, 0};

  task automatic row(input bit sv, input bit ss, input int sig, input int ph, input bit dv,
                     input bit [1:0] dout, input int im, input int qm, input bit se);
    vec_t r;
    r = '{sv, ss, sig, ph, dv, dout, im, qm, se};
    tab.push_back(r);
  endtask

  initial begin
    model_reset();

    // Symbol 11, then 01 back-to-back without a second sym_start.
    row(1, 1,  60, 0, 0, 2'b00,     0,     0, 0);
    row(1, 0,  60, 1, 0, 2'b00,     0,     0, 0);
    row(1, 0, -60, 2, 0, 2'b00,     0,     0, 0);
    row(1, 0, -60, 3, 1, 2'b11,  7200,  7200, 0);
    row(1, 0,  60, 0, 0, 2'b11,  7200,  7200, 0);
    row(1, 0, -60, 1, 0, 2'b11,  7200,  7200, 0);
    row(1, 0, -60, 2, 0, 2'b11,  7200,  7200, 0);
    row(1, 0,  60, 3, 1, 2'b01, -7200,  7200, 0);
    // Symbol 10 with a three-cycle gap between samples 1 and 2.
    row(1, 0, -60, 0, 0, 2'b01, -7200,  7200, 0);
    row(1, 0,  60, 1, 0, 2'b01, -7200,  7200, 0);
    row(0, 0,  99, 2, 0, 2'b01, -7200,  7200, 0);
    row(0, 1,  99, 2, 0, 2'b01, -7200,  7200, 0);
    row(0, 0,  99, 2, 0, 2'b01, -7200,  7200, 0);
    row(1, 0,  60, 2, 0, 2'b01, -7200,  7200, 0);
    row(1, 0, -60, 3, 1, 2'b10,  7200, -7200, 0);
    // All-zero signal slices to 11.
    row(1, 0,   0, 0, 0, 2'b10,  7200, -7200, 0);
    row(1, 0,   0, 1, 0, 2'b10,  7200, -7200, 0);
    row(1, 0,   0, 2, 0, 2'b10,  7200, -7200, 0);
    row(1, 0,   0, 3, 1, 2'b11,     0,     0, 0);
    // Resync on sample 2, then a full symbol 00.
    row(1, 1,  60, 0, 0, 2'b11,     0,     0, 0);
    row(1, 0,  60, 1, 0, 2'b11,     0,     0, 0);
    row(1, 1, -60, 0, 0, 2'b11,     0,     0, 1);
    row(1, 0, -60, 1, 0, 2'b11,     0,     0, 0);
    row(1, 0,  60, 2, 0, 2'b11,     0,     0, 0);
    row(1, 0,  60, 3, 1, 2'b00, -7200, -7200, 0);
    row(0, 1,  60, 0, 0, 2'b00, -7200, -7200, 0);

    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset data_out", data_out, 0);
    chk("reset data_valid", data_valid, 0);
    chk("reset i_metric", i_metric, 0);
    chk("reset q_metric", q_metric, 0);
    chk("reset sync_err", sync_err, 0);
    rst = 1'b1;
    step(1, 0, 50, 60, 0);  // no sym_start yet: ignored

    foreach (tab[n]) begin
      step(tab[n].sv, tab[n].ss, tab[n].sig, sin_t[tab[n].ph], cos_t[tab[n].ph]);
      chk($sformatf("vec%0d data_valid", n), data_valid, tab[n].dv);
      chk($sformatf("vec%0d data_out", n), data_out, tab[n].dout);
      chk($sformatf("vec%0d i_metric", n), i_metric, tab[n].im);
      chk($sformatf("vec%0d q_metric", n), q_metric, tab[n].qm);
      chk($sformatf("vec%0d sync_err", n), sync_err, tab[n].se);
    end

    // Reset after sample 2 of a symbol: partial symbol discarded.
    step(1, 1, 60, 0, 60);
    step(1, 0, 60, 60, 0);
    step(1, 0, -60, 0, -60);
    rst = 1'b0;
    step(1, 0, -60, -60, 0);
    chk("midrst data_valid", data_valid, 0);
    chk("midrst data_out", data_out, 0);
    chk("midrst i_metric", i_metric, 0);
    chk("midrst q_metric", q_metric, 0);
    rst = 1'b1;
    step(1, 0, -60, -60, 0);  // idle after reset, no sym_start
    chk("postrst no data_valid", data_valid, 0);
    step(1, 1, -60, 0, 60);
    step(1, 0, 60, 60, 0);
    step(1, 0, 60, 0, -60);
    step(1, 0, -60, -60, 0);
    chk("postrst data_valid", data_valid, 1);
    chk("postrst data_out", data_out, 2'b10);
    chk("postrst i_metric", i_metric, 7200);
    chk("postrst q_metric", q_metric, -7200);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(149) != 0);
      step($urandom_range(3) != 0, $urandom_range(9) == 0,
           int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
           int'($urandom_range(255)) - 128);
    end
    rst = 1'b1;
    sample_valid = 1'b0;
    sym_start    = 1'b0;

    // Worst-case magnitude over 16 samples must not wrap in 20 bits.
    for (int k = 0; k < 16; k++) begin
      sv16  = 1'b1;
      ss16  = (k == 0);
      sig16 = -8'sd128;
      sin16 = -8'sd128;
      cos16 = -8'sd128;
      @(posedge clk);
      #1;
      if (k == 14) chk("ovf early data_valid", dv16, 0);
    end
    sv16 = 1'b0;
    ss16 = 1'b0;
    chk("ovf data_valid", dv16, 1);
    chk("ovf i_metric", i16, 262144);
    chk("ovf q_metric", q16, 262144);
    chk("ovf data_out", do16, 2'b11);
    chk("ovf sync_err", se16, 0);
    @(posedge clk);
    #1;
    chk("ovf pulse width", dv16, 0);
    chk("ovf hold i_metric", i16, 262144);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qam_demod.md
Name: qam_demod

Overview:
- 4-QAM (QPSK) coherent demodulator: the receive-side counterpart of the team's qam_mixer.
- Correlates the incoming 8-bit passband samples against the local sin/cos references over one symbol period, then slices the sign of each correlation to recover the 2-bit symbol.
- Sits after the ADC/channel model and the reference NCO. The instantiating level must present signal_in, sin_ref and cos_ref sample-aligned, including compensation of the mixer's one-cycle register delay.

Parameters:
- SPS, 16, samples per symbol (≥2).
- SAMPLE_W, 8, signed width of signal_in, sin_ref and cos_ref.
- ACC_W, 20, signed accumulator width. Legal only if ACC_W ≥ 2*SAMPLE_W + ceil(log2(SPS)), which guarantees no overflow (elaboration-time check).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-low.
- sample_valid, in, 1, the sample on signal_in/sin_ref/cos_ref is valid this cycle.
- sym_start, in, 1, qualified by sample_valid; marks this sample as the first of a symbol.
- signal_in, in, SAMPLE_W, signed received sample.
- sin_ref, in, SAMPLE_W, signed local sine reference.
- cos_ref, in, SAMPLE_W, signed local cosine reference.
- data_out, out, 2, recovered symbol. [1] = sine arm, [0] = cosine arm; same bit mapping as the transmitter.
- data_valid, out, 1, one-cycle pulse; data_out and the metrics are new.
- i_metric, out, ACC_W, final sine-arm correlation of the last symbol.
- q_metric, out, ACC_W, final cosine-arm correlation of the last symbol.
- sync_err, out, 1, one-cycle pulse; sym_start arrived mid-symbol.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, sample counter 0, both accumulators 0. Outputs: data_out=0, data_valid=0, i_metric=0, q_metric=0, sync_err=0. Applies mid-symbol; any partial symbol is discarded and no data_valid is produced for it.
- Per accepted sample (sample_valid=1):
  - p_i = signal_in*sin_ref, p_q = signal_in*cos_ref, each full-precision signed 2*SAMPLE_W.
  - Products are sign-extended to ACC_W; no truncation or saturation.
- sample_valid=0: state, counter and accumulators hold; gaps of any length are allowed inside a symbol.
- FSM states:
  - IDLE: ignores samples until sample_valid & sym_start. On that sample: acc ← product, cnt ← 1, go to INTEG.
  - INTEG, normal sample: acc ← acc + product, cnt ← cnt+1.
  - INTEG, sample with cnt == SPS-1 (last sample), on the same edge:
    - i_metric ← acc_i + p_i, q_metric ← acc_q + p_q.
    - data_out[1] ← (final I ≥ 0), data_out[0] ← (final Q ≥ 0). A zero metric slices to 1.
    - data_valid ← 1 for one cycle.
    - cnt ← 0, acc ← 0, stay in INTEG (free-running back-to-back symbols).
  - INTEG, cnt == 0 (first sample of the next symbol): the sample is accepted whether sym_start is 0 or 1; no error.
- Latency: data_valid asserts the cycle after the posedge that accepts the last sample of a symbol.
- Resync:
  - Trigger: sym_start=1 with sample_valid=1 while in INTEG and 1 ≤ cnt ≤ SPS-1.
  - Partial accumulation is discarded; acc ← product, cnt ← 1.
  - sync_err pulses for one cycle; no data_valid for the aborted symbol.
  - This also applies when cnt == SPS-1: sym_start wins over completion.
- sym_start with sample_valid=0: ignored.
- Metrics and data_out hold their values between data_valid pulses.

Decomposition:
- Package qam_pkg:
  - SAMPLE_W default and SYM_W=2.
  - Bit positions SIN_BIT=1, COS_BIT=0, shared with qam_mixer.
  - demod state enum {IDLE, INTEG}.
- Sub-module qam_correlator: one multiply-accumulate arm.
  - Ports: clk, rst, clear/load, en, a, b, acc output.
  - Instantiated twice (sine arm, cosine arm).
  - FSM, counter and slicer stay in qam_demod.

Test Plan:
- Setup for all tests: SPS=4, references sin={0,60,0,-60}, cos={60,0,-60,0}, sample_valid=1 unless noted.
- Symbol 11: signal={60,60,-60,-60} with sym_start on sample 0 -> one cycle after sample 3: data_valid=1, data_out=2'b11, i_metric=7200, q_metric=7200.
- Symbol 01: signal={60,-60,-60,60} -> data_out=2'b01, i_metric=-7200, q_metric=7200. Back-to-back with the 11 symbol (no second sym_start) gives two data_valid pulses exactly 4 cycles apart.
- Gaps and zero slice: symbol 10 (signal={-60,60,60,-60}) with sample_valid=0 for 3 cycles between samples 1 and 2 -> data_out=2'b10, metrics ±7200 unaffected. All-zero signal -> data_out=2'b11, metrics 0.
- Resync: sym_start reasserted on sample 2 -> sync_err pulses once, no data_valid; the next 4 samples of symbol 00 -> data_out=2'b00, metrics -7200/-7200.
- Reset mid-symbol: rst=0 after sample 2 for one cycle -> all outputs 0, no data_valid; the next sym_start-aligned symbol decodes correctly.
- Overflow check: SPS=16, SAMPLE_W=8, ACC_W=20, all inputs -128 -> i_metric = q_metric = 262144 with no wrap. The elaboration check rejects ACC_W=19.
